hsv_to_rgb565: RTL

- Inverse of the RGB565→HSV front end: converts a streaming HSV pixel (hue in degrees, 8-bit saturation, 8-bit value) back to RGB565.
- Fully pipelined, one pixel per clock, fixed 4-cycle latency, valid-only interface with no backpressure.
- Sits after colour-detect/thresholding to re-render processed pixels, for example when driving the display/VGA writer with masked or recoloured frames.

---
 rtl/hsv_pkg.sv | 25 ++
 rtl/hsv_sector.sv | 90 +++++++++
 rtl/hsv_to_rgb565.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hsv_pkg.sv
// Shared constants, sector encoding and the /255 approximation used by the
// HSV-to-RGB datapath and its companion HSV blocks.
package hsv_pkg;

  localparam int HUE_MAX     = 360;
  localparam int SECTOR_DEG  = 60;
  localparam int HSV_LATENCY = 4;

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_t;

  // Exact x/255 for every product of two 8-bit operands, no divider needed.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [16:0] s;
    s = 17'(x) + 17'(x >> 8) + 17'd1;
    return s[15:8];
  endfunction

endpackage

// File: rtl/hsv_sector.sv
// First HSV stage: clamps hue/sat/value, finds the 60-degree sector with a
// compare chain and scales the in-sector remainder to an 8-bit fraction.
module hsv_sector
  import hsv_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [IN_W-1:0] i_hue,
  input  logic [IN_W-1:0] i_sat,
  input  logic [IN_W-1:0] i_value,
  input  logic            i_valid,
  output logic [7:0]      o_s8,
  output logic [7:0]      o_v8,
  output logic [7:0]      o_f8,
  output sector_t         o_sec,
  output logic            o_valid
);

  function automatic logic [8:0] clamp_hue(input logic [IN_W-1:0] x);
    return (x >= IN_W'(HUE_MAX)) ? 9'd0 : x[8:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [IN_W-1:0] x);
    return (x > IN_W'(255)) ? 8'hFF : x[7:0];
  endfunction

  logic [8:0] hue_c;
  logic [8:0] base_c;
  logic [5:0] rem_c;
  sector_t    sec_c;

  logic [7:0] s8_p1_d, s8_p1_q;
  logic [7:0] v8_p1_d, v8_p1_q;
  logic [7:0] f8_p1_d, f8_p1_q;
  sector_t    sec_p1_d, sec_p1_q;
  logic       vld_p1_d, vld_p1_q;

  always_comb begin
    hue_c = clamp_hue(i_hue);
    if (hue_c >= 9'(5 * SECTOR_DEG)) begin
      sec_c = SEC_5; base_c = 9'(5 * SECTOR_DEG);
    end else if (hue_c >= 9'(4 * SECTOR_DEG)) begin
      sec_c = SEC_4; base_c = 9'(4 * SECTOR_DEG);
    end else if (hue_c >= 9'(3 * SECTOR_DEG)) begin
      sec_c = SEC_3; base_c = 9'(3 * SECTOR_DEG);
    end else if (hue_c >= 9'(2 * SECTOR_DEG)) begin
      sec_c = SEC_2; base_c = 9'(2 * SECTOR_DEG);
    end else if (hue_c >= 9'(SECTOR_DEG)) begin
      sec_c = SEC_1; base_c = 9'(SECTOR_DEG);
    end else begin
      sec_c = SEC_0; base_c = 9'd0;
    end
    rem_c = 6'(hue_c - base_c);

    s8_p1_d  = s8_p1_q;
    v8_p1_d  = v8_p1_q;
    f8_p1_d  = f8_p1_q;
    sec_p1_d = sec_p1_q;
    vld_p1_d = i_valid;
    if (i_valid) begin
      s8_p1_d  = sat8(i_sat);
      v8_p1_d  = sat8(i_value);
      // rem*4.25 maps 0..59 onto 0..250
      f8_p1_d  = {rem_c, 2'b00} + 8'(rem_c >> 2);
      sec_p1_d = sec_c;
    end
  end

  // ---- stage p1 boundary ----
  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_p1_q <= 1'b0;
    else         vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge i_clk) begin
    s8_p1_q  <= s8_p1_d;
    v8_p1_q  <= v8_p1_d;
    f8_p1_q  <= f8_p1_d;
    sec_p1_q <= sec_p1_d;
  end

  assign o_s8    = s8_p1_q;
  assign o_v8    = v8_p1_q;
  assign o_f8    = f8_p1_q;
  assign o_sec   = sec_p1_q;
  assign o_valid = vld_p1_q;

endmodule

// File: rtl/hsv_to_rgb565.sv
// Streaming HSV -> RGB565 converter, 4-stage pipeline, valid-only interface.
// Define HSV2RGB_RGB888_EN to add the full-precision o_rgb888 output.
module hsv_to_rgb565
  import hsv_pkg::*;
#(
  parameter int LATENCY = HSV_LATENCY,
  parameter int IN_W    = 16
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [IN_W-1:0] i_hue,
  input  logic [IN_W-1:0] i_sat,
  input  logic [IN_W-1:0] i_value,
  input  logic            i_valid,
`ifdef HSV2RGB_RGB888_EN
  output logic [23:0]     o_rgb888,
`endif
  output logic [15:0]     o_data,
  output logic            o_valid
);

  if (LATENCY != HSV_LATENCY) begin : g_bad_latency
    $error("hsv_to_rgb565: LATENCY is fixed at 4");
  end

  logic [7:0] s8_p1, v8_p1, f8_p1;
  sector_t    sec_p1;
  logic       vld_p1;

  hsv_sector #(.IN_W(IN_W)) u_sector (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_hue   (i_hue),
    .i_sat   (i_sat),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_s8    (s8_p1),
    .o_v8    (v8_p1),
    .o_f8    (f8_p1),
    .o_sec   (sec_p1),
    .o_valid (vld_p1)
  );

  logic [7:0] sf_p2_d, sf_p2_q, sft_p2_d, sft_p2_q, p_p2_d, p_p2_q, v8_p2_d, v8_p2_q;
  sector_t    sec_p2_d, sec_p2_q;
  logic       vld_p2_d, vld_p2_q;

  logic [7:0] p_p3_d, p_p3_q, q_p3_d, q_p3_q, t_p3_d, t_p3_q, v8_p3_d, v8_p3_q;
  sector_t    sec_p3_d, sec_p3_q;
  logic       vld_p3_d, vld_p3_q;

  logic [7:0]  r_c, g_c, b_c;
  logic [15:0] data_p4_d, data_p4_q;
  logic        vld_p4_d, vld_p4_q;

  always_comb begin
    sf_p2_d  = sf_p2_q;
    sft_p2_d = sft_p2_q;
    p_p2_d   = p_p2_q;
    v8_p2_d  = v8_p2_q;
    sec_p2_d = sec_p2_q;
    vld_p2_d = vld_p1;
    if (vld_p1) begin
      sf_p2_d  = div255(16'(s8_p1) * 16'(f8_p1));
      sft_p2_d = div255(16'(s8_p1) * 16'(8'd255 - f8_p1));
      p_p2_d   = div255(16'(v8_p1) * 16'(8'd255 - s8_p1));
      v8_p2_d  = v8_p1;
      sec_p2_d = sec_p1;
    end
  end

  // ---- stage p2 boundary ----
  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_p2_q <= 1'b0;
    else         vld_p2_q <= vld_p2_d;
  end

  always_ff @(posedge i_clk) begin
    sf_p2_q  <= sf_p2_d;
    sft_p2_q <= sft_p2_d;
    p_p2_q   <= p_p2_d;
    v8_p2_q  <= v8_p2_d;
    sec_p2_q <= sec_p2_d;
  end

  always_comb begin
    p_p3_d   = p_p3_q;
    q_p3_d   = q_p3_q;
    t_p3_d   = t_p3_q;
    v8_p3_d  = v8_p3_q;
    sec_p3_d = sec_p3_q;
    vld_p3_d = vld_p2_q;
    if (vld_p2_q) begin
      p_p3_d   = p_p2_q;
      q_p3_d   = div255(16'(v8_p2_q) * 16'(8'd255 - sf_p2_q));
      t_p3_d   = div255(16'(v8_p2_q) * 16'(8'd255 - sft_p2_q));
      v8_p3_d  = v8_p2_q;
      sec_p3_d = sec_p2_q;
    end
  end

  // ---- stage p3 boundary ----
  always_ff @(posedge i_clk) begin
    if (!i_rstn) vld_p3_q <= 1'b0;
    else         vld_p3_q <= vld_p3_d;
  end

  always_ff @(posedge i_clk) begin
    p_p3_q   <= p_p3_d;
    q_p3_q   <= q_p3_d;
    t_p3_q   <= t_p3_d;
    v8_p3_q  <= v8_p3_d;
    sec_p3_q <= sec_p3_d;
  end

  always_comb begin
    unique case (sec_p3_q)
      SEC_0:   begin r_c = v8_p3_q; g_c = t_p3_q;  b_c = p_p3_q;  end
      SEC_1:   begin r_c = q_p3_q;  g_c = v8_p3_q; b_c = p_p3_q;  end
      SEC_2:   begin r_c = p_p3_q;  g_c = v8_p3_q; b_c = t_p3_q;  end
      SEC_3:   begin r_c = p_p3_q;  g_c = q_p3_q;  b_c = v8_p3_q; end
      SEC_4:   begin r_c = t_p3_q;  g_c = p_p3_q;  b_c = v8_p3_q; end
      default: begin r_c = v8_p3_q; g_c = p_p3_q;  b_c = q_p3_q;  end
    endcase
    data_p4_d = vld_p3_q ? {r_c[7:3], g_c[7:2], b_c[7:3]} : data_p4_q;
    vld_p4_d  = vld_p3_q;
  end

  // ---- stage p4 boundary (output registers clear on reset) ----
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      data_p4_q <= 16'd0;
      vld_p4_q  <= 1'b0;
    end else begin
      data_p4_q <= data_p4_d;
      vld_p4_q  <= vld_p4_d;
    end
  end

  assign o_data  = data_p4_q;
  assign o_valid = vld_p4_q;

`ifdef HSV2RGB_RGB888_EN
  logic [23:0] rgb_p4_d, rgb_p4_q;

  always_comb begin
    rgb_p4_d = vld_p3_q ? {r_c, g_c, b_c} : rgb_p4_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) rgb_p4_q <= 24'd0;
    else         rgb_p4_q <= rgb_p4_d;
  end

  assign o_rgb888 = rgb_p4_q;
`endif

endmodule
